// File: rtl/arbiter_weighted.sv
// Weighted round-robin arbiter: each grant carries a credit loaded from the winner's weight,
// spent per acknowledge (ACK mode) or per granted cycle (cycle mode), with optional hold timeout.
module arbiter_weighted #(
  parameter int PORTS                 = 4,
  parameter int WEIGHT_WIDTH          = 4,
  parameter bit ARB_BLOCK_ACK         = 1'b1,
  parameter bit ARB_LSB_HIGH_PRIORITY = 1'b0,
  parameter int TIMEOUT               = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS-1:0]              request,
  input  logic [PORTS-1:0]              acknowledge,
  input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
  output logic [PORTS-1:0]              grant,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_encoded,
  output logic                          preempt
);

  localparam int IDX_W = $clog2(PORTS);
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Pointer value that makes the first search start at index 0 (LSB) or PORTS-1 (MSB)
  localparam logic [IDX_W-1:0] PTR_RESET = ARB_LSB_HIGH_PRIORITY ? IDX_W'(PORTS - 1) : IDX_W'(0);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANTED = 1'b1} state_t;

  state_t                  state_r, state_s;
  logic [PORTS-1:0]        grant_r, grant_s;
  logic [IDX_W-1:0]        enc_r, enc_s;
  logic [IDX_W-1:0]        last_r, last_s;
  logic [WEIGHT_WIDTH-1:0] credit_r, credit_s;
  logic [TMR_W-1:0]        timer_r, timer_s;
  logic                    preempt_s;
  logic                    rearb_s;
  logic                    ack_g_s;
  logic                    req_g_s;
  logic [IDX_W:0]          search_s;
  logic [WEIGHT_WIDTH-1:0] weight_a [PORTS];

  for (genvar i = 0; i < PORTS; i++) begin : g_weight
    assign weight_a[i] = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

  // Returns {found, index} of the first requester after 'last' in search order; 'last' itself is checked last.
  function automatic logic [IDX_W:0] rr_search(input logic [PORTS-1:0] req, input logic [IDX_W-1:0] last);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = 1; k <= PORTS; k++) begin
      if (ARB_LSB_HIGH_PRIORITY) begin
        idx = int'(last) + k;
        if (idx >= PORTS) idx = idx - PORTS;
      end else begin
        idx = int'(last) - k;
        if (idx < 0) idx = idx + PORTS;
      end
      if (!res[IDX_W] && req[idx[IDX_W-1:0]]) res = {1'b1, idx[IDX_W-1:0]};
    end
    return res;
  endfunction

  assign ack_g_s = |(acknowledge & grant_r);
  assign req_g_s = |(request & grant_r);

  // Release decision for the current grantee, then same-cycle re-arbitration
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    enc_s     = enc_r;
    last_s    = last_r;
    credit_s  = credit_r;
    timer_s   = timer_r;
    preempt_s = 1'b0;
    rearb_s   = 1'b0;
    search_s  = '0;

    case (state_r)
      ST_IDLE: begin
        rearb_s = 1'b1;
      end
      ST_GRANTED: begin
        if (ARB_BLOCK_ACK) begin
          // An acknowledge wins over a timeout landing in the same cycle
          if (ack_g_s) begin
            if (credit_r > WEIGHT_WIDTH'(1) && req_g_s) begin
              credit_s = credit_r - WEIGHT_WIDTH'(1);
              timer_s  = '0;
            end else begin
              rearb_s = 1'b1;
            end
          end else if (TIMEOUT > 0 && timer_r == TMR_W'(TIMEOUT)) begin
            rearb_s   = 1'b1;
            preempt_s = 1'b1;
          end else if (TIMEOUT > 0) begin
            timer_s = timer_r + TMR_W'(1);
          end else begin
            timer_s = timer_r;
          end
        end else begin
          if (!req_g_s || credit_r == WEIGHT_WIDTH'(1)) begin
            rearb_s = 1'b1;
          end else begin
            credit_s = credit_r - WEIGHT_WIDTH'(1);
          end
        end
        if (rearb_s) begin
          last_s = enc_r;
        end else begin
          last_s = last_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        rearb_s = 1'b1;
      end
    endcase

    if (rearb_s) begin
      search_s = rr_search(request, last_s);
      if (search_s[IDX_W]) begin
        state_s  = ST_GRANTED;
        enc_s    = search_s[IDX_W-1:0];
        grant_s  = {{(PORTS-1){1'b0}}, 1'b1} << search_s[IDX_W-1:0];
        credit_s = (weight_a[search_s[IDX_W-1:0]] == '0) ? WEIGHT_WIDTH'(1)
                                                          : weight_a[search_s[IDX_W-1:0]];
        timer_s  = '0;
      end else begin
        state_s  = ST_IDLE;
        enc_s    = '0;
        grant_s  = '0;
        credit_s = '0;
        timer_s  = '0;
      end
    end else begin
      search_s = '0;
    end
  end

  // Arbiter state, grant, pointer, credit and hold-timer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      grant_r  <= '0;
      enc_r    <= '0;
      last_r   <= PTR_RESET;
      credit_r <= '0;
      timer_r  <= '0;
    end else begin
      state_r  <= state_s;
      grant_r  <= grant_s;
      enc_r    <= enc_s;
      last_r   <= last_s;
      credit_r <= credit_s;
      timer_r  <= timer_s;
    end
  end

  assign grant         = grant_r;
  assign grant_valid   = (state_r == ST_GRANTED);
  assign grant_encoded = enc_r;
  assign preempt       = preempt_s;

endmodule

// File: tb/tb_arbiter_weighted.sv
// Bench for arbiter_weighted: three configurations driven by shared directed stimulus,
// checked every cycle against a behavioural model plus hand-computed grant sequences.
`timescale 1ns/1ps
module tb_arbiter_weighted;

  localparam int NI = 3;  // 0: ACK/LSB/TIMEOUT=8, 1: cycle/LSB, 2: ACK/MSB

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req;
  logic [15:0] w;
  logic [3:0]  ack [NI];
  logic [3:0]  g_o [NI];
  logic        v_o [NI];
  logic [1:0]  e_o [NI];
  logic        p_o [NI];

  int m_cur  [NI];   // granted port, -1 when idle
  int m_cred [NI];
  int m_tmr  [NI];
  int m_last [NI];   // last released port
  bit auto_ack [NI];
  bit chk_en;
  int n_pass;
  int n_total;

  int exp_t1a [6] = '{0, 1, 2, 3, 0, 1};
  int exp_t1c [6] = '{3, 2, 1, 0, 3, 2};
  int exp_t2a [7] = '{0, 1, 1, 1, 2, 3, 0};
  int exp_t5b [8] = '{0, 0, 3, 3, 0, 0, 3, 3};

  always #5 clk = ~clk;

  arbiter_weighted #(.PORTS(4), .WEIGHT_WIDTH(4), .ARB_BLOCK_ACK(1'b1),
                     .ARB_LSB_HIGH_PRIORITY(1'b1), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .request(req), .acknowledge(ack[0]), .weight(w),
    .grant(g_o[0]), .grant_valid(v_o[0]), .grant_encoded(e_o[0]), .preempt(p_o[0]));

  arbiter_weighted #(.PORTS(4), .WEIGHT_WIDTH(4), .ARB_BLOCK_ACK(1'b0),
                     .ARB_LSB_HIGH_PRIORITY(1'b1), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .request(req), .acknowledge(ack[1]), .weight(w),
    .grant(g_o[1]), .grant_valid(v_o[1]), .grant_encoded(e_o[1]), .preempt(p_o[1]));

  arbiter_weighted #(.PORTS(4), .WEIGHT_WIDTH(4), .ARB_BLOCK_ACK(1'b1),
                     .ARB_LSB_HIGH_PRIORITY(1'b0), .TIMEOUT(0)) dut_c (
    .clk(clk), .rst(rst), .request(req), .acknowledge(ack[2]), .weight(w),
    .grant(g_o[2]), .grant_valid(v_o[2]), .grant_encoded(e_o[2]), .preempt(p_o[2]));

  function automatic int p_blk(input int i); return (i == 1) ? 0 : 1; endfunction
  function automatic int p_lsb(input int i); return (i == 2) ? 0 : 1; endfunction
  function automatic int p_tmo(input int i); return (i == 0) ? 8 : 0; endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // First requester after 'last' walking in the configured direction, 'last' itself checked last.
  function automatic int pick(input int i, input logic [3:0] r, input int last);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (p_lsb(i) != 0) ? (last + k) % 4 : (last + 4 - k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_cur[i]  = -1;
      m_cred[i] = 0;
      m_tmr[i]  = 0;
      m_last[i] = (p_lsb(i) != 0) ? 3 : 0;
    end
  endtask

  // One clock of the model, reading the inputs present at the edge.
  task automatic model_step(input int i);
    bit rel;
    int g;
    int wt;
    rel = (m_cur[i] < 0);
    if (!rel) begin
      g = m_cur[i];
      if (p_blk(i) != 0) begin
        if (ack[i][g]) begin
          if (m_cred[i] > 1 && req[g]) begin
            m_cred[i]--;
            m_tmr[i] = 0;
          end else rel = 1'b1;
        end else if (p_tmo(i) > 0 && m_tmr[i] == p_tmo(i)) rel = 1'b1;
        else m_tmr[i]++;
      end else begin
        if (!req[g] || m_cred[i] == 1) rel = 1'b1;
        else m_cred[i]--;
      end
      if (rel) m_last[i] = g;
    end
    if (rel) begin
      m_cur[i] = pick(i, req, m_last[i]);
      if (m_cur[i] >= 0) begin
        wt = int'(w[m_cur[i]*4 +: 4]);
        m_cred[i] = (wt == 0) ? 1 : wt;
      end else m_cred[i] = 0;
      m_tmr[i] = 0;
    end
  endtask

  function automatic logic [3:0] exp_grant(input int i);
    return (m_cur[i] < 0) ? 4'b0000 : (4'b0001 << m_cur[i]);
  endfunction

  function automatic logic exp_pre(input int i);
    return (p_blk(i) != 0) && (m_cur[i] >= 0) && (p_tmo(i) > 0) &&
           (m_tmr[i] == p_tmo(i)) && !ack[i][m_cur[i]];
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    #1;
    for (int i = 0; i < NI; i++) if (auto_ack[i]) ack[i] = exp_grant(i);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    model_reset();
    req = 4'b1111;
    for (int i = 0; i < NI; i++) begin
      ack[i] = 4'b0000;
      auto_ack[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++)
      check($sformatf("reset_inst%0d", i), 32'({g_o[i], v_o[i], e_o[i], p_o[i]}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  // Per-cycle comparison of every instance against the model
  initial forever begin
    @(negedge clk);
    if (chk_en && !rst) begin
      for (int i = 0; i < NI; i++) begin
        logic [2:0] ee;
        ee = (m_cur[i] < 0) ? 3'd0 : 3'(m_cur[i]);
        check($sformatf("model_inst%0d t=%0t", i, $time),
              32'({g_o[i], v_o[i], e_o[i], p_o[i]}),
              32'({exp_grant(i), (m_cur[i] >= 0), ee[1:0], exp_pre(i)}));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    chk_en = 1'b0;
    req = 4'b0000;
    w = 16'h1111;
    for (int i = 0; i < NI; i++) begin
      ack[i] = 4'b0000;
      auto_ack[i] = 1'b1;
    end

    // Equal weights, everybody requesting, ack every grant
    w = 16'h1111;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("t1_seq_a[%0d]", k), 32'({v_o[0], e_o[0]}), 32'({1'b1, 2'(exp_t1a[k])}));
      check($sformatf("t1_seq_c[%0d]", k), 32'({v_o[2], e_o[2]}), 32'({1'b1, 2'(exp_t1c[k])}));
    end

    // Port 1 weighted 3
    w = 16'h1131;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("t2_seq_a[%0d]", k), 32'({v_o[0], e_o[0]}), 32'({1'b1, 2'(exp_t2a[k])}));
    end

    // Asynchronous reset while granted
    #2;
    chk_en = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++)
      check($sformatf("async_rst_inst%0d", i), 32'({g_o[i], v_o[i]}), 32'd0);

    // Lone requester port 2, weight 2: grant never drops across reloads
    w = 16'h0200;
    do_reset();
    req = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      for (int i = 0; i < NI; i++)
        check($sformatf("t3_hold_inst%0d[%0d]", i, k), 32'({g_o[i], v_o[i]}), 32'({4'b0100, 1'b1}));
    end

    // Port 0 stalls without ack: timeout preemption on instance 0
    w = 16'h1111;
    do_reset();
    req = 4'b0011;
    auto_ack[0] = 1'b0;
    ack[0] = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("t4_preempt[%0d]", k), 32'(p_o[0]), (k == 8) ? 32'd1 : 32'd0);
      check($sformatf("t4_grant[%0d]", k), 32'(g_o[0]), (k <= 8) ? 32'h1 : 32'h2);
    end

    // Same, but the ack lands in the timeout cycle
    do_reset();
    req = 4'b0011;
    auto_ack[0] = 1'b0;
    ack[0] = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      ack[0] = (k == 8) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      check($sformatf("t4b_preempt[%0d]", k), 32'(p_o[0]), 32'd0);
      check($sformatf("t4b_grant[%0d]", k), 32'(g_o[0]), (k <= 8) ? 32'h1 : 32'h2);
    end

    // Cycle mode, weights 2, ports 0 and 3
    w = 16'h2222;
    do_reset();
    req = 4'b1001;
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("t5_seq_b[%0d]", k), 32'({v_o[1], e_o[1]}), 32'({1'b1, 2'(exp_t5b[k])}));
    end

    // Cycle mode, port 0 drops its request in its first granted cycle
    do_reset();
    req = 4'b1001;
    tick();
    req = 4'b1000;
    @(negedge clk);
    check("t5b_first_b", 32'(g_o[1]), 32'h1);
    tick();
    @(negedge clk);
    check("t5b_moved_b", 32'(g_o[1]), 32'h8);
    tick();
    @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arbiter_weighted.md
Name: arbiter_weighted

Overview:
Weighted round-robin arbiter, successor to the basic round-robin arbiter. Each port gets a programmable credit count: the number of acknowledged transfers (ACK mode) or granted cycles (cycle mode) it may hold before the grant rotates. An optional hold timeout forcibly preempts a stalled grantee. Sits in front of shared muxes (AXI-stream mux, Ethernet frame mux) wherever ports need unequal bandwidth shares.

Parameters:
PORTS, 4, number of requesters (>=2).
WEIGHT_WIDTH, 4, bits per port weight.
ARB_BLOCK_ACK, 1, 1 = credit consumed per acknowledge and grant held until ack; 0 = credit consumed per granted cycle and grant held only while request is high.
ARB_LSB_HIGH_PRIORITY, 0, 1 = search order is increasing index; 0 = decreasing index.
TIMEOUT, 0, cycles a grant may be held without acknowledge before preemption; 0 disables (used only when ARB_BLOCK_ACK=1).

Ports:
clk  input  1  clock, all logic rising-edge.
rst  input  1  asynchronous, active-high reset.
request  input  PORTS  per-port request.
acknowledge  input  PORTS  per-port transfer acknowledge; ignored on ports not currently granted.
weight  input  PORTS*WEIGHT_WIDTH  per-port credit, port i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; quasi-static.
grant  output  PORTS  one-hot grant, registered.
grant_valid  output  1  high when any grant bit is set.
grant_encoded  output  $clog2(PORTS)  index of granted port; 0 when grant_valid=0.
preempt  output  1  one-cycle pulse in the cycle a timeout release is decided.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset: grant=0, grant_valid=0, grant_encoded=0, preempt=0, credit counter=0, hold timer=0. The RR pointer is set so the first search starts at index 0 (LSB mode) or PORTS-1 (MSB mode). Reset asserted mid-grant drops the grant immediately.
- States: IDLE (grant_valid=0) and GRANTED.
- IDLE: any request in cycle N -> GRANTED with grant registered at N+1 (1-cycle latency). Winner is the first requester found in search order, starting just after the last released port and wrapping.
- On grant load: credit = weight[winner]; weight 0 is treated as 1. Weight is sampled only at load. Hold timer is cleared.
- ACK mode, grant on port g:
  - The grant is held regardless of request[g] until an acknowledge or a timeout.
  - acknowledge[g] with credit>1 and request[g]=1: credit decrements, grant is held, timer clears.
  - acknowledge[g] with credit==1, or with request[g]=0: release.
- Cycle mode, grant on port g:
  - Each granted cycle decrements credit.
  - Release at the end of the cycle where credit==1, or in any cycle with request[g]=0.
- Release in cycle N (no bubble): the pointer moves to g, and arbitration runs over request in cycle N. The new grant appears at N+1.
  - If g is the only requester, it is re-granted with a fresh credit and grant stays continuously high.
  - If no port is requesting, the block returns to IDLE with grant=0 at N+1.
- Timeout (TIMEOUT>0, ACK mode): the timer counts granted cycles without acknowledge[g]. When it reaches TIMEOUT, that cycle is treated as a release: preempt=1 for that cycle only, remaining credit is forfeited, and the pointer advances past g.
- An acknowledge arriving in the same cycle as the timeout takes precedence: it is a normal ack, and preempt=0.
- acknowledge on non-granted ports has no effect. grant is always zero or one-hot.
- Timer width is $clog2(TIMEOUT+1); credit counter width is WEIGHT_WIDTH. No arithmetic overflow is possible.

Test Plan:
- Reset: hold rst=1 with request=4'b1111 -> grant=0, grant_valid=0, grant_encoded=0, preempt=0. Assert rst async mid-grant -> grant clears without waiting for a clock edge.
- ACK mode, all weights 1, LSB=1, request=4'b1111, acknowledge=grant every cycle -> grant_encoded sequence 0,1,2,3,0,1 with no idle cycles.
- ACK mode, weights {p0=1, p1=3, p2=1, p3=1}, request=4'b1111, ack every cycle -> sequence 0,1,1,1,2,3,0.
- Single requester port 2, weight=2, acked every cycle -> grant=4'b0100 held continuously across credit reloads; grant_valid never drops.
- TIMEOUT=8: port 0 granted and never acks, port 1 requesting -> 8 cycles after the grant, preempt pulses high for 1 cycle and grant=4'b0010 on the next cycle. Variant with an ack in the timeout cycle -> preempt stays 0.
- Cycle mode, weights 2, request=4'b1001, LSB=1 -> port 0 granted 2 cycles, then port 3 granted 2 cycles, then repeat. Drop request[0] in its first granted cycle -> grant moves to port 3 on the next cycle.
